// File: rtl/voice_pitch_resampler_if.sv
// Read-side bus between the voice-change sample FIFO and its consumer.
// master: the resampler (issues pops); slave: the FIFO.
interface voice_pitch_resampler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 12
) ();
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_empty;
  logic [LEVEL_WIDTH-1:0] fifo_level;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    input  fifo_level
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    output fifo_level
  );
endinterface

// File: rtl/voice_pitch_resampler.sv
// Pitch resampler: pops PCM from the sample FIFO and emits one linearly interpolated sample per sample_req.
// Build option: define VOICE_PITCH_ROUND_EN to round the interpolation product half up instead of flooring.
module voice_pitch_resampler #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 8,
  parameter int STEP_WIDTH  = 10,
  parameter int LEVEL_WIDTH = 12,
  parameter int START_LEVEL = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [STEP_WIDTH-1:0]        step_i,
  input  logic                         sample_req_i,
  voice_pitch_resampler_if.master      fifo,
  output logic signed [DATA_WIDTH-1:0] dout_o,
  output logic                         dout_valid_o,
  output logic                         underflow_o,
  output logic                         overrun_o
);

  localparam int PW = DATA_WIDTH + FRAC_WIDTH + 2;
  localparam int AW = FRAC_WIDTH + 2;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME0 = 3'd1,
    ST_PRIME1 = 3'd2,
    ST_RUN    = 3'd3,
    ST_CALC   = 3'd4,
    ST_ADV_RD = 3'd5,
    ST_ADV_WT = 3'd6
  } state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   s0_q, s0_d, s1_q, s1_d;
  logic        [FRAC_WIDTH-1:0]   phase_q, phase_d;
  logic        [1:0]              n_q, n_d;
  logic        [STEP_WIDTH-1:0]   step_q, step_d;
  logic                           wait_q, wait_d;
  logic                           sil_q, sil_d;
  logic signed [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                           dout_valid_q, dout_valid_d;
  logic                           underflow_q, underflow_d;
  logic                           overrun_q, overrun_d;
  logic                           rd_en_s;

  logic signed [DATA_WIDTH:0]     diff_s;
  logic signed [FRAC_WIDTH:0]     phase_s;
  logic signed [PW-1:0]           prod_s, prod_rnd_s, prod_sh_s, y_wide_s;
  logic signed [DATA_WIDTH-1:0]   y_s;
  logic        [AW-1:0]           acc_s;

  function automatic logic signed [DATA_WIDTH-1:0] sat_f(input logic signed [PW-1:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Interpolation datapath: y = s0 + ((s1 - s0) * phase) >>> FRAC_WIDTH
  assign diff_s  = {s1_q[DATA_WIDTH-1], s1_q} - {s0_q[DATA_WIDTH-1], s0_q};
  assign phase_s = {1'b0, phase_q};
  assign prod_s  = PW'(diff_s) * PW'(phase_s);
`ifdef VOICE_PITCH_ROUND_EN
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_WIDTH - 1);
  assign prod_rnd_s = prod_s + RND;
`else
  assign prod_rnd_s = prod_s;
`endif
  assign prod_sh_s = prod_rnd_s >>> FRAC_WIDTH;
  assign y_wide_s  = PW'(s0_q) + prod_sh_s;
  assign y_s       = sat_f(y_wide_s);
  assign acc_s     = AW'(phase_q) + AW'(step_q);

  assign fifo.fifo_rd_en = rd_en_s;
  assign dout_o          = dout_q;
  assign dout_valid_o    = dout_valid_q;
  assign underflow_o     = underflow_q;
  assign overrun_o       = overrun_q;

  // Next-state, pop control and output computation
  always_comb begin
    state_d      = state_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    phase_d      = phase_q;
    n_d          = n_q;
    step_d       = step_q;
    wait_d       = wait_q;
    sil_d        = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    underflow_d  = 1'b0;
    overrun_d    = 1'b0;
    rd_en_s      = 1'b0;

    // A request accepted in IDLE answers with silence on the same two-cycle latency as RUN.
    if (sil_q) begin
      dout_d       = '0;
      dout_valid_d = 1'b1;
    end else begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sil_d = sample_req_i;
        if (fifo.fifo_level >= LEVEL_WIDTH'(START_LEVEL)) begin
          state_d = ST_PRIME0;
          phase_d = '0;
          wait_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME0, ST_PRIME1: begin
        overrun_d = sample_req_i;
        if (wait_q) begin
          wait_d = 1'b0;
          if (state_q == ST_PRIME0) begin
            s0_d    = fifo.fifo_rd_data;
            state_d = ST_PRIME1;
          end else begin
            s1_d    = fifo.fifo_rd_data;
            state_d = ST_RUN;
          end
        end else if (fifo.fifo_empty) begin
          underflow_d = 1'b1;
          s0_d        = '0;
          s1_d        = '0;
          phase_d     = '0;
          n_d         = 2'd0;
          state_d     = ST_IDLE;
        end else begin
          rd_en_s = 1'b1;
          wait_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (sample_req_i) begin
          step_d  = step_i;
          state_d = ST_CALC;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CALC: begin
        overrun_d    = sample_req_i;
        dout_d       = y_s;
        dout_valid_d = 1'b1;
        phase_d      = acc_s[FRAC_WIDTH-1:0];
        n_d          = acc_s[FRAC_WIDTH+1:FRAC_WIDTH];
        if (acc_s[FRAC_WIDTH+1:FRAC_WIDTH] == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_ADV_RD;
        end
      end
      ST_ADV_RD: begin
        overrun_d = sample_req_i;
        if (fifo.fifo_empty) begin
          underflow_d = 1'b1;
          s0_d        = '0;
          s1_d        = '0;
          phase_d     = '0;
          n_d         = 2'd0;
          state_d     = ST_IDLE;
        end else begin
          rd_en_s = 1'b1;
          state_d = ST_ADV_WT;
        end
      end
      ST_ADV_WT: begin
        overrun_d = sample_req_i;
        s0_d      = s1_q;
        s1_d      = fifo.fifo_rd_data;
        n_d       = n_q - 2'd1;
        if (n_q > 2'd1) begin
          state_d = ST_ADV_RD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s0_q         <= '0;
      s1_q         <= '0;
      phase_q      <= '0;
      n_q          <= 2'd0;
      step_q       <= '0;
      wait_q       <= 1'b0;
      sil_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      phase_q      <= phase_d;
      n_q          <= n_d;
      step_q       <= step_d;
      wait_q       <= wait_d;
      sil_q        <= sil_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      underflow_q  <= underflow_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
